// File: rtl/fb_sched_pkg.sv
// Shared types and defaults for the frame-buffer write scheduler.
package fb_sched_pkg;

    typedef enum logic [1:0] {
        CLEAR     = 2'd0,
        RENDER    = 2'd1,
        WAIT_SWAP = 2'd2
    } state_t;

    localparam int          FB_DEPTH_DEF    = 57600;
    localparam logic [15:0] CLEAR_COLOR_DEF = 16'h0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requesting index at or
// after ptr (wrapping) and reports the pointer to use after the grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] ptr_next
);

    int          idx;
    logic        found;
    logic [PW-1:0] gidx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        gidx  = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
            end
        end
        ptr_next = ptr;
        // Pointer only moves on an actual transfer so idle cycles keep fairness.
        if (advance && found)
            ptr_next = (int'(gidx) == N - 1) ? '0 : gidx + PW'(1);
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// Owns front/back selection of the double-buffered frame buffer and shares its
// write port between the clear sweep and round-robin arbitrated renderers.
module fb_write_scheduler
    import fb_sched_pkg::*;
#(
    parameter int                    NUM_REQ     = 4,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    FB_DEPTH    = FB_DEPTH_DEF,
    parameter logic [DATA_WIDTH-1:0] CLEAR_COLOR = DATA_WIDTH'(CLEAR_COLOR_DEF)
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                frame_done_in,
    input  logic                                render_done_in,
    input  logic [NUM_REQ-1:0]                  req_valid_in,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr_in,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_color_in,
    output logic [NUM_REQ-1:0]                  req_ready_out,
    output logic                                we_a_out,
    output logic                                we_b_out,
    output logic [ADDR_WIDTH-1:0]               wr_addr_out,
    output logic [DATA_WIDTH-1:0]               wr_data_out,
    output logic                                front_sel_out,
    output logic                                render_start_out,
    output logic                                clearing_out,
    output logic [7:0]                          overrun_count_out
);

    localparam int                    PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_DEPTH - 1);
    localparam logic [31:0]           DEPTH_U   = 32'(FB_DEPTH);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [PTR_W-1:0]        ptr, ptr_nxt;
    logic [NUM_REQ-1:0]      req_masked, grant;
    logic                    clear_last, clear_done, swap, overrun_evt, xfer, in_range;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_color;

    assign req_masked    = (state == RENDER) ? req_valid_in : '0;
    assign xfer          = |grant;
    assign req_ready_out = grant;
    assign clearing_out  = (state == CLEAR);
    assign clear_last    = (state == CLEAR) && (clr_addr == LAST_ADDR);
    assign in_range      = 32'(sel_addr) < DEPTH_U;

    rr_arbiter #(.N(NUM_REQ), .PW(PTR_W)) u_arb (
        .req      (req_masked),
        .ptr      (ptr),
        .advance  (xfer),
        .grant    (grant),
        .ptr_next (ptr_nxt)
    );

    always_comb begin
        sel_addr  = '0;
        sel_color = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr  = sel_addr  | req_addr_in[i];
                sel_color = sel_color | req_color_in[i];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        swap        = 1'b0;
        overrun_evt = 1'b0;
        case (state)
            CLEAR: begin
                overrun_evt = frame_done_in;
                if (clear_last) state_nxt = RENDER;
            end
            RENDER: begin
                if (render_done_in) begin
                    if (frame_done_in) begin
                        swap      = 1'b1;
                        state_nxt = CLEAR;
                    end else begin
                        state_nxt = WAIT_SWAP;
                    end
                end else begin
                    overrun_evt = frame_done_in;
                end
            end
            WAIT_SWAP: begin
                if (frame_done_in) begin
                    swap      = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= CLEAR;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            clr_addr          <= '0;
            ptr               <= '0;
            front_sel_out     <= 1'b0;
            overrun_count_out <= '0;
            clear_done        <= 1'b0;
            render_start_out  <= 1'b0;
            we_a_out          <= 1'b0;
            we_b_out          <= 1'b0;
            wr_addr_out       <= '0;
            wr_data_out       <= '0;
        end else begin
            ptr              <= ptr_nxt;
            clear_done       <= clear_last;
            render_start_out <= clear_done;

            if (swap) begin
                front_sel_out <= ~front_sel_out;
                clr_addr      <= '0;
            end else if (state == CLEAR) begin
                clr_addr <= clear_last ? '0 : clr_addr + ADDR_WIDTH'(1);
            end

            if (overrun_evt && overrun_count_out != 8'hFF)
                overrun_count_out <= overrun_count_out + 8'd1;

            // Enables use the selection in force when the write was issued.
            we_a_out <= 1'b0;
            we_b_out <= 1'b0;
            if (state == CLEAR) begin
                we_a_out    <= front_sel_out;
                we_b_out    <= ~front_sel_out;
                wr_addr_out <= clr_addr;
                wr_data_out <= CLEAR_COLOR;
            end else if (xfer && in_range) begin
                we_a_out    <= front_sel_out;
                we_b_out    <= ~front_sel_out;
                wr_addr_out <= sel_addr;
                wr_data_out <= sel_color;
            end
        end
    end

endmodule
